// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding, op codes and
// default widths.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 8;
    localparam int unsigned LSU_DATA_W = 8;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_agen.sv
// Effective-address generator: base plus two's-complement offset, wrapping modulo 2**ADDR_W.
module lsu_agen
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_offset,
    output logic [ADDR_W-1:0] o_ea
);

    // Same-width add drops the carry, which is exactly the modulo wrap we want.
    assign o_ea = i_base + i_offset;

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute stage and a 256x8 data memory port.
// Optional LSU_BOUNDS_EN macro enables the effective-address bounds check against ADDR_LIMIT.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned        ADDR_W     = LSU_ADDR_W,
    parameter int unsigned        DATA_W     = LSU_DATA_W,
    parameter logic [ADDR_W-1:0]  ADDR_LIMIT = 'hEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_op,
    input  logic [ADDR_W-1:0] i_req_base,
    input  logic [ADDR_W-1:0] i_req_offset,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_data,
    output logic              o_resp_fault,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    lsu_state_e        r_state;
    logic              r_op;
    logic [ADDR_W-1:0] r_ea;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp_data;
    logic [ADDR_W-1:0] w_ea;

    lsu_agen #(
        .ADDR_W (ADDR_W)
    ) u_agen (
        .i_base   (i_req_base),
        .i_offset (i_req_offset),
        .o_ea     (w_ea)
    );

`ifdef LSU_BOUNDS_EN
    logic r_resp_fault;
    logic w_out_of_range;

    assign w_out_of_range = (w_ea > ADDR_LIMIT);
    assign o_resp_fault   = r_resp_fault;
`else
    logic w_unused_limit;

    assign w_unused_limit = ^ADDR_LIMIT;
    assign o_resp_fault   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOAD;
            r_ea        <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
`ifdef LSU_BOUNDS_EN
            r_resp_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_op        <= i_req_op;
                        r_wdata     <= i_req_wdata;
                        r_ea        <= w_ea;
                        r_resp_data <= '0;
`ifdef LSU_BOUNDS_EN
                        // Out-of-range requests bypass the memory cycle entirely.
                        r_resp_fault <= w_out_of_range;
                        r_state      <= w_out_of_range ? S_RESP : S_ACCESS;
`else
                        r_state     <= S_ACCESS;
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_op == OP_LOAD) begin
                        r_resp_data <= i_mem_rdata;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from registered state so an async reset drops them at once.
    assign o_mem_write  = (r_state == S_ACCESS) && (r_op == OP_STORE);
    assign o_mem_read   = (r_state == S_ACCESS) && (r_op == OP_LOAD);
    assign o_mem_addr   = r_ea;
    assign o_mem_wdata  = r_wdata;
    assign o_resp_data  = r_resp_data;
    assign o_resp_valid = (r_state == S_RESP);
    assign o_req_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a memory model drives mem_rdata, a reference byte
// array predicts responses and memory accesses, and monitors compare as the DUT presents them.
module tb_load_store_unit;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_base;
    logic [7:0] req_offset;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_fault;
    logic [7:0] mem_addr;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fault;
    } resp_t;

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
    } acc_t;

    resp_t resp_q[$];
    acc_t  acc_q[$];

    logic [7:0] mem[256];
    logic       mem_loaded = 1'b0;
    logic [7:0] ref_mem[256];

    load_store_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_base   (req_base),
        .i_req_offset (req_offset),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_data  (resp_data),
        .o_resp_fault (resp_fault),
        .o_mem_addr   (mem_addr),
        .o_mem_write  (mem_write),
        .o_mem_read   (mem_read),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write commits on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: memory-side accesses and response handshakes against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);
            if (mem_read || mem_write) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_access", {23'd0, mem_write, mem_addr}, 32'hFFFF);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check("acc_addr", {24'd0, mem_addr}, {24'd0, a.addr});
                    check("acc_write", {31'd0, mem_write}, {31'd0, a.wr});
                    if (a.wr) check("acc_wdata", {24'd0, mem_wdata}, {24'd0, a.wdata});
                end
            end
            if (resp_valid && resp_ready) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {24'd0, resp_data}, 32'hFFFF);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_data", {24'd0, resp_data}, {24'd0, r.data});
                    check("resp_fault", {31'd0, resp_fault}, {31'd0, r.fault});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; returns #1 after the accepting edge. abort=1 skips the model update.
    task automatic do_req(input logic op, input logic [7:0] base, input logic [7:0] off,
                          input logic [7:0] wd, input bit abort);
        logic [7:0] ea;
        bit         acc;
        bit         flt;
        acc = 1'b0;
        req_valid  = 1'b1;
        req_op     = op;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = req_ready;
            tick();
        end
        req_valid  = 1'b0;
        req_op     = 1'($urandom);
        req_base   = 8'($urandom);
        req_offset = 8'($urandom);
        req_wdata  = 8'($urandom);
        if (!acc) begin
            check("req_accept_timeout", 32'd0, 32'd1);
        end else if (!abort) begin
            ea = base + off;
            flt = 1'b0;
`ifdef LSU_BOUNDS_EN
            flt = (ea > 8'hEF);
`endif
            if (flt) begin
                resp_q.push_back('{data: 8'h00, fault: 1'b1});
            end else if (op) begin
                acc_q.push_back('{addr: ea, wr: 1'b1, wdata: wd});
                ref_mem[ea] = wd;
                resp_q.push_back('{data: 8'h00, fault: 1'b0});
            end else begin
                acc_q.push_back('{addr: ea, wr: 1'b0, wdata: 8'h00});
                resp_q.push_back('{data: ref_mem[ea], fault: 1'b0});
            end
        end
    endtask

    // Wait for resp_valid (resp_ready random meanwhile, which must be ignored), stall, accept.
    task automatic wait_resp(input int stall);
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin
            resp_ready = 1'($urandom);
            tick();
            n++;
        end
        if (!resp_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            resp_ready = 1'b0;
            for (int i = 0; i < stall; i++) tick();
            resp_ready = 1'b1;
            tick();
        end
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 1'b0;
        req_base = 8'h00;
        req_offset = 8'h00;
        req_wdata = 8'h00;
        resp_ready = 1'b0;
        repeat (3) tick();

        // Reset values.
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_wr_rd", {30'd0, mem_write, mem_read}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_resp", {23'd0, resp_fault, resp_data}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        end

        // Store then load of the same EA; strobe width and latency.
        do_req(1'b1, 8'h10, 8'h05, 8'hA5, 1'b0);
        check("st_addr", {24'd0, mem_addr}, 32'h15);
        check("st_write", {30'd0, mem_write, mem_read}, 32'd2);
        check("st_busy_ready", {30'd0, busy, req_ready}, 32'd2);
        tick();
        check("st_write_1cyc", {31'd0, mem_write}, 32'd0);
        check("st_resp_valid", {31'd0, resp_valid}, 32'd1);
        wait_resp(0);
        do_req(1'b0, 8'h10, 8'h05, 8'h00, 1'b0);
        check("ld_read", {30'd0, mem_write, mem_read}, 32'd1);
        tick();
        check("ld_lat_valid", {31'd0, resp_valid}, 32'd1);
        check("ld_lat_data", {24'd0, resp_data}, 32'hA5);
        wait_resp(0);

        // EA wrap.
        do_req(1'b0, 8'hFF, 8'h02, 8'h00, 1'b0);
        check("wrap_up", {24'd0, mem_addr}, 32'h01);
        wait_resp(0);
        do_req(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
`ifndef LSU_BOUNDS_EN
        check("wrap_down", {24'd0, mem_addr}, 32'hFF);
`endif
        wait_resp(1);

        // Backpressure with a competing request held on the input.
        do_req(1'b0, 8'h15, 8'h00, 8'h00, 1'b0);
        tick();
        req_valid = 1'b1;
        req_op = 1'b1;
        req_base = 8'h40;
        req_offset = 8'h00;
        req_wdata = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid_ready", {30'd0, resp_valid, req_ready}, 32'd2);
            check("bp_data", {24'd0, resp_data}, 32'hA5);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        resp_ready = 1'b0;
        check("bp_back_idle", {30'd0, resp_valid, req_ready}, 32'd1);
        tick();

        // Reset cuts a store mid-ACCESS.
        do_req(1'b1, 8'h20, 8'h00, 8'h77, 1'b0);
        wait_resp(0);
        do_req(1'b1, 8'h1F, 8'h01, 8'h3C, 1'b1);
        check("cut_write_before", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("cut_write_drop", {31'd0, mem_write}, 32'd0);
        check("cut_idle", {29'd0, busy, resp_valid, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_req(1'b0, 8'h20, 8'h00, 8'h00, 1'b0);
        tick();
        check("cut_prior_value", {24'd0, resp_data}, 32'h77);
        wait_resp(0);

        // Store to EA 0xF0: faults only when the bounds check is built in.
        do_req(1'b1, 8'hF0, 8'h00, 8'h99, 1'b0);
`ifdef LSU_BOUNDS_EN
        check("oob_fast_fault", {29'd0, resp_valid, resp_fault, mem_write}, 32'd6);
`else
        check("oob_normal_store", {29'd0, resp_valid, resp_fault, mem_write}, 32'd1);
        tick();
        check("oob_no_fault", {30'd0, resp_valid, resp_fault}, 32'd2);
`endif
        wait_resp(1);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            logic [7:0] b;
            logic [7:0] o;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            o = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            do_req(1'($urandom), b, o, 8'($urandom), 1'b0);
            wait_resp(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (3) tick();
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("acc_q_drained", acc_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
